csr_trap_ctrl: RTL and testbench
================================

// Module: csr_trap_ctrl
// PURPOSE
// Trap/interrupt sequencer that owns one csrfile commit write channel. Accepts exception and
// mret requests from commit, detects enabled pending interrupts from csrfile mip/mie/mstatus,
// performs the multi-cycle CSR update sequence (mepc, mcause, mtval, mstatus), then issues a
// one-cycle fetch redirect to the trap vector or mepc. Sits between commit and csrfile.
// PARAMETERS
// DATA_WIDTH      32   CSR data width, equals `REG_DATA_WIDTH
// CSR_ADDR_WIDTH  12   CSR address width, equals `CSR_ADDR_WIDTH
// PORTS
// clk                                 in   1    clock
// rst                                 in   1    async reset, active-high
// commit_trapctrl_exc_valid           in   1    synchronous exception request
// commit_trapctrl_exc_cause           in   DW   mcause value for exception (bit DW-1 = 0)
// commit_trapctrl_exc_pc              in   DW   faulting instruction pc
// commit_trapctrl_exc_tval            in   DW   mtval value
// commit_trapctrl_mret_valid          in   1    mret request
// commit_trapctrl_int_allow           in   1    commit at instruction boundary; interrupt may be taken
// commit_trapctrl_int_pc              in   DW   pc of next uncommitted instruction (interrupt mepc)
// trapctrl_commit_ready               out  1    1 only in IDLE; request accepted on valid && ready
// trapctrl_commit_int_taken           out  1    1-cycle pulse: interrupt accepted this edge
// csrf_all_mie_data/mip_data/mstatus_data/mepc_data  in  DW each  live csrfile values
// csrf_trapctrl_mtvec_data            in   DW   live mtvec
// trapctrl_csrf_write_addr            out  AW   CSR write address
// trapctrl_csrf_write_data            out  DW   CSR write data
// trapctrl_csrf_we                    out  1    CSR write enable
// trapctrl_fetch_redirect_valid       out  1    1-cycle redirect pulse
// trapctrl_fetch_redirect_pc          out  DW   redirect target
// BEHAVIOUR
// - States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, M_MSTATUS, REDIRECT.
// - Outputs decode from registered state/latches only; no comb path from request inputs to outputs.
// - Reset (async): state=IDLE, all latches 0; ready=1, we=0, addr=0, data=0, redirect_valid=0,
//   redirect_pc=0, int_taken=0. Reset mid-sequence aborts immediately; partial CSR writes stand.
// - Interrupt pending: p = mip & mie & {DW{mstatus[3]}}; take when p!=0 && int_allow in IDLE.
//   Code priority MEI(11) > MSI(3) > MTI(7); cause = {1'b1, code}; tval = 0; epc = int_pc.
// - Accept priority in IDLE, same edge: exception > interrupt > mret. Losers ignored (no queueing).
// - On accept, latch cause/epc/tval, mstatus snapshot, mtvec, mepc; int_taken pulses next cycle.
// - Trap path: W_MEPC(addr `CSR_MEPC, data epc) -> W_MCAUSE(cause) -> W_MTVAL(tval) ->
//   W_MSTATUS(snapshot with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11) -> REDIRECT -> IDLE.
// - mret path: M_MSTATUS(snapshot with MIE=MPIE, MPIE=1, MPP=2'b11) -> REDIRECT -> IDLE.
// - we=1 exactly in W_*/M_* states, one write per cycle. Latency: accept edge E0; writes in cycles
//   E0+1..E0+4 (trap) or E0+1 (mret); redirect_valid in next cycle; ready=1 the cycle after.
// - Redirect pc: trap: base=mtvec&~3; if mtvec[1:0]==1 and interrupt, base+4*code, else base.
//   mret: latched mepc. mtvec[1:0]>=2 treated as direct. Arithmetic mod 2^DW.
// - Requests while ready=0 are ignored; commit must hold them. Inputs changing mid-sequence have
//   no effect (latched values used). redirect_pc holds last value outside REDIRECT.
// TESTING
// - Reset asserted during W_MCAUSE -> same cycle we=0, ready=1; after release IDLE, no redirect.
// - exc cause=2, pc=0x80000100, tval=0xdeadbeef, mtvec=0x80000000, mstatus=0x8 -> writes
//   0x341=0x80000100, 0x342=2, 0x343=0xdeadbeef, 0x300=0x1880; redirect 0x80000000 at E0+5.
// - mip=0x880, mie=0x880, mstatus=0x8, int_allow=1, int_pc=0x200, mtvec=0x1001 -> MEI chosen,
//   mcause=0x8000000b, mtval=0, redirect pc=0x102c; int_taken pulse once.
// - mstatus=0x80, mepc=0x400, mret -> one write 0x300=0x1888, redirect 0x400 at E0+2, ready E0+3.
// - exc, mret and pending interrupt same edge -> exception sequence only; mret/int ignored; also
//   mstatus[3]=0 with mip&mie!=0 -> no interrupt accepted, ready stays 1.
// - Back-to-back: second exc held valid from E0 -> accepted exactly at ready edge, no cycle lost.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// Trap/interrupt sequencer: accepts exceptions, interrupts and mret from commit, performs the
// CSR update sequence on a single csrfile write channel, then issues a one-cycle fetch redirect.
module csr_trap_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      commit_trapctrl_exc_valid,
  input  logic [DATA_WIDTH-1:0]     commit_trapctrl_exc_cause,
  input  logic [DATA_WIDTH-1:0]     commit_trapctrl_exc_pc,
  input  logic [DATA_WIDTH-1:0]     commit_trapctrl_exc_tval,
  input  logic                      commit_trapctrl_mret_valid,
  input  logic                      commit_trapctrl_int_allow,
  input  logic [DATA_WIDTH-1:0]     commit_trapctrl_int_pc,
  output logic                      trapctrl_commit_ready,
  output logic                      trapctrl_commit_int_taken,
  input  logic [DATA_WIDTH-1:0]     csrf_all_mie_data,
  input  logic [DATA_WIDTH-1:0]     csrf_all_mip_data,
  input  logic [DATA_WIDTH-1:0]     csrf_all_mstatus_data,
  input  logic [DATA_WIDTH-1:0]     csrf_all_mepc_data,
  input  logic [DATA_WIDTH-1:0]     csrf_trapctrl_mtvec_data,
  output logic [CSR_ADDR_WIDTH-1:0] trapctrl_csrf_write_addr,
  output logic [DATA_WIDTH-1:0]     trapctrl_csrf_write_data,
  output logic                      trapctrl_csrf_we,
  output logic                      trapctrl_fetch_redirect_valid,
  output logic [DATA_WIDTH-1:0]     trapctrl_fetch_redirect_pc
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = CSR_ADDR_WIDTH;

  localparam logic [AW-1:0] CSR_MSTATUS = AW'(12'h300);
  localparam logic [AW-1:0] CSR_MEPC    = AW'(12'h341);
  localparam logic [AW-1:0] CSR_MCAUSE  = AW'(12'h342);
  localparam logic [AW-1:0] CSR_MTVAL   = AW'(12'h343);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MTVAL,
    S_W_MSTATUS,
    S_M_MSTATUS,
    S_REDIRECT
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] cause_q, cause_d;
  logic [DW-1:0] epc_q, epc_d;
  logic [DW-1:0] tval_q, tval_d;
  logic [DW-1:0] mstatus_q, mstatus_d;
  logic [DW-1:0] mtvec_q, mtvec_d;
  logic [DW-1:0] mepc_q, mepc_d;
  logic          is_int_q, is_int_d;
  logic          int_taken_q, int_taken_d;
  logic [DW-1:0] redirect_pc_q, redirect_pc_d;

  logic [DW-1:0] int_pend;
  logic [3:0]    int_code;
  logic          idle;
  logic          accept_exc, accept_int, accept_mret;

  assign idle     = (state_q == S_IDLE);
  assign int_pend = csrf_all_mip_data & csrf_all_mie_data & {DW{csrf_all_mstatus_data[3]}};

  // Fixed priority: external > software > timer.
  always_comb begin
    int_code = 4'd0;
    if (int_pend[11])      int_code = 4'd11;
    else if (int_pend[3])  int_code = 4'd3;
    else if (int_pend[7])  int_code = 4'd7;
  end

  assign accept_exc  = idle && commit_trapctrl_exc_valid;
  assign accept_int  = idle && !commit_trapctrl_exc_valid && commit_trapctrl_int_allow &&
                       (int_pend != '0);
  assign accept_mret = idle && !commit_trapctrl_exc_valid && !accept_int &&
                       commit_trapctrl_mret_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_exc || accept_int) state_d = S_W_MEPC;
        else if (accept_mret)         state_d = S_M_MSTATUS;
      end
      S_W_MEPC:    state_d = S_W_MCAUSE;
      S_W_MCAUSE:  state_d = S_W_MTVAL;
      S_W_MTVAL:   state_d = S_W_MSTATUS;
      S_W_MSTATUS: state_d = S_REDIRECT;
      S_M_MSTATUS: state_d = S_REDIRECT;
      S_REDIRECT:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  logic [DW-1:0] trap_base;
  logic [DW-1:0] trap_target;

  assign trap_base   = mtvec_q & ~DW'(3);
  assign trap_target = (mtvec_q[1:0] == 2'b01 && is_int_q) ?
                       trap_base + ({{(DW-4){1'b0}}, cause_q[3:0]} << 2) : trap_base;

  // Request latches and redirect target
  always_comb begin
    cause_d       = cause_q;
    epc_d         = epc_q;
    tval_d        = tval_q;
    mstatus_d     = mstatus_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    is_int_d      = is_int_q;
    int_taken_d   = accept_int;
    redirect_pc_d = redirect_pc_q;
    if (accept_exc || accept_int || accept_mret) begin
      mstatus_d = csrf_all_mstatus_data;
      mtvec_d   = csrf_trapctrl_mtvec_data;
      mepc_d    = csrf_all_mepc_data;
      is_int_d  = accept_int;
    end
    if (accept_exc) begin
      cause_d = commit_trapctrl_exc_cause;
      epc_d   = commit_trapctrl_exc_pc;
      tval_d  = commit_trapctrl_exc_tval;
    end else if (accept_int) begin
      cause_d = {1'b1, {(DW-5){1'b0}}, int_code};
      epc_d   = commit_trapctrl_int_pc;
      tval_d  = '0;
    end
    if (state_q == S_W_MSTATUS)      redirect_pc_d = trap_target;
    else if (state_q == S_M_MSTATUS) redirect_pc_d = mepc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q       <= '0;
      epc_q         <= '0;
      tval_q        <= '0;
      mstatus_q     <= '0;
      mtvec_q       <= '0;
      mepc_q        <= '0;
      is_int_q      <= 1'b0;
      int_taken_q   <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      tval_q        <= tval_d;
      mstatus_q     <= mstatus_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      is_int_q      <= is_int_d;
      int_taken_q   <= int_taken_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  logic [DW-1:0] trap_mstatus;
  logic [DW-1:0] mret_mstatus;

  always_comb begin
    trap_mstatus        = mstatus_q;
    trap_mstatus[7]     = mstatus_q[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;
    mret_mstatus        = mstatus_q;
    mret_mstatus[3]     = mstatus_q[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b11;
  end

  // Output decode from registered state and latches only
  always_comb begin
    trapctrl_csrf_we         = 1'b0;
    trapctrl_csrf_write_addr = '0;
    trapctrl_csrf_write_data = '0;
    case (state_q)
      S_W_MEPC: begin
        trapctrl_csrf_we         = 1'b1;
        trapctrl_csrf_write_addr = CSR_MEPC;
        trapctrl_csrf_write_data = epc_q;
      end
      S_W_MCAUSE: begin
        trapctrl_csrf_we         = 1'b1;
        trapctrl_csrf_write_addr = CSR_MCAUSE;
        trapctrl_csrf_write_data = cause_q;
      end
      S_W_MTVAL: begin
        trapctrl_csrf_we         = 1'b1;
        trapctrl_csrf_write_addr = CSR_MTVAL;
        trapctrl_csrf_write_data = tval_q;
      end
      S_W_MSTATUS: begin
        trapctrl_csrf_we         = 1'b1;
        trapctrl_csrf_write_addr = CSR_MSTATUS;
        trapctrl_csrf_write_data = trap_mstatus;
      end
      S_M_MSTATUS: begin
        trapctrl_csrf_we         = 1'b1;
        trapctrl_csrf_write_addr = CSR_MSTATUS;
        trapctrl_csrf_write_data = mret_mstatus;
      end
      default: ;
    endcase
  end

  assign trapctrl_commit_ready         = idle;
  assign trapctrl_commit_int_taken     = int_taken_q;
  assign trapctrl_fetch_redirect_valid = (state_q == S_REDIRECT);
  assign trapctrl_fetch_redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: drives trap, interrupt and mret requests and checks each
// CSR write, redirect pulse and handshake against hand-computed values.
module tb_csr_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        exc_valid;
  logic [31:0] exc_cause, exc_pc, exc_tval;
  logic        mret_valid, int_allow;
  logic [31:0] int_pc;
  logic        ready, int_taken;
  logic [31:0] mie, mip, mstatus, mepc, mtvec;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        we;
  logic        rd_valid;
  logic [31:0] rd_pc;

  int n_tests = 0;
  int n_fail  = 0;

  csr_trap_ctrl #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .commit_trapctrl_exc_valid     (exc_valid),
    .commit_trapctrl_exc_cause     (exc_cause),
    .commit_trapctrl_exc_pc        (exc_pc),
    .commit_trapctrl_exc_tval      (exc_tval),
    .commit_trapctrl_mret_valid    (mret_valid),
    .commit_trapctrl_int_allow     (int_allow),
    .commit_trapctrl_int_pc        (int_pc),
    .trapctrl_commit_ready         (ready),
    .trapctrl_commit_int_taken     (int_taken),
    .csrf_all_mie_data             (mie),
    .csrf_all_mip_data             (mip),
    .csrf_all_mstatus_data         (mstatus),
    .csrf_all_mepc_data            (mepc),
    .csrf_trapctrl_mtvec_data      (mtvec),
    .trapctrl_csrf_write_addr      (waddr),
    .trapctrl_csrf_write_data      (wdata),
    .trapctrl_csrf_we              (we),
    .trapctrl_fetch_redirect_valid (rd_valid),
    .trapctrl_fetch_redirect_pc    (rd_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [11:0] a, input logic [31:0] d);
    $display("[TB] %s: write 0x%03h <= 0x%08h", tag, a, d);
    check({tag, " we"}, {31'd0, we}, 32'd1);
    check({tag, " addr"}, {20'd0, waddr}, {20'd0, a});
    check({tag, " data"}, wdata, d);
    check({tag, " ready"}, {31'd0, ready}, 32'd0);
    tick();
  endtask

  task automatic expect_redirect(input string tag, input logic [31:0] pc);
    $display("[TB] %s: redirect to 0x%08h", tag, pc);
    check({tag, " rd_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, " rd_pc"}, rd_pc, pc);
    check({tag, " rd we"}, {31'd0, we}, 32'd0);
    check({tag, " rd ready"}, {31'd0, ready}, 32'd0);
    tick();
    check({tag, " ready after"}, {31'd0, ready}, 32'd1);
    check({tag, " rd_valid after"}, {31'd0, rd_valid}, 32'd0);
    check({tag, " rd_pc hold"}, rd_pc, pc);
  endtask

  task automatic clear_reqs();
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    int_allow  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    exc_cause = '0; exc_pc = '0; exc_tval = '0; int_pc = '0;
    mie = '0; mip = '0; mstatus = '0; mepc = '0; mtvec = '0;
    tick();
    tick();
    $display("[TB] reset state");
    check("rst ready", {31'd0, ready}, 32'd1);
    check("rst we", {31'd0, we}, 32'd0);
    check("rst addr", {20'd0, waddr}, 32'd0);
    check("rst data", wdata, 32'd0);
    check("rst rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst rd_pc", rd_pc, 32'd0);
    check("rst int_taken", {31'd0, int_taken}, 32'd0);
    rst = 1'b0;
    tick();

    // Reset asserted mid-sequence
    $display("[TB] reset during W_MCAUSE");
    exc_valid = 1'b1; exc_cause = 32'd4; exc_pc = 32'h100; exc_tval = 32'h1; mtvec = 32'h800;
    tick();
    clear_reqs();
    tick();
    check("midrst pre addr", {20'd0, waddr}, 32'h342);
    rst = 1'b1;
    #1;
    check("midrst we", {31'd0, we}, 32'd0);
    check("midrst ready", {31'd0, ready}, 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst no redirect", {31'd0, rd_valid}, 32'd0);
      check("midrst idle", {31'd0, ready}, 32'd1);
    end

    // Plain exception
    exc_valid = 1'b1; exc_cause = 32'd2; exc_pc = 32'h80000100; exc_tval = 32'hdeadbeef;
    mtvec = 32'h80000000; mstatus = 32'h8;
    tick();
    clear_reqs();
    check("exc int_taken", {31'd0, int_taken}, 32'd0);
    expect_write("exc mepc", 12'h341, 32'h80000100);
    expect_write("exc mcause", 12'h342, 32'd2);
    expect_write("exc mtval", 12'h343, 32'hdeadbeef);
    expect_write("exc mstatus", 12'h300, 32'h1880);
    expect_redirect("exc", 32'h80000000);

    // Vectored machine external interrupt
    mip = 32'h880; mie = 32'h880; mstatus = 32'h8; int_allow = 1'b1; int_pc = 32'h200;
    mtvec = 32'h1001;
    tick();
    clear_reqs();
    check("int taken pulse", {31'd0, int_taken}, 32'd1);
    expect_write("int mepc", 12'h341, 32'h200);
    check("int taken once", {31'd0, int_taken}, 32'd0);
    expect_write("int mcause", 12'h342, 32'h8000000b);
    expect_write("int mtval", 12'h343, 32'd0);
    expect_write("int mstatus", 12'h300, 32'h1880);
    expect_redirect("int", 32'h102c);
    mip = '0; mie = '0;

    // mret
    mstatus = 32'h80; mepc = 32'h400; mret_valid = 1'b1;
    tick();
    clear_reqs();
    expect_write("mret mstatus", 12'h300, 32'h1888);
    expect_redirect("mret", 32'h400);

    // Exception, mret and interrupt on the same edge
    exc_valid = 1'b1; mret_valid = 1'b1; int_allow = 1'b1;
    exc_cause = 32'd5; exc_pc = 32'h100; exc_tval = 32'h11; int_pc = 32'h999;
    mip = 32'h8; mie = 32'h8; mstatus = 32'h8; mtvec = 32'h2001; mepc = 32'h777;
    tick();
    clear_reqs();
    check("prio int_taken", {31'd0, int_taken}, 32'd0);
    expect_write("prio mepc", 12'h341, 32'h100);
    expect_write("prio mcause", 12'h342, 32'd5);
    expect_write("prio mtval", 12'h343, 32'h11);
    expect_write("prio mstatus", 12'h300, 32'h1880);
    expect_redirect("prio", 32'h2000);

    // Globally disabled interrupts are not taken
    $display("[TB] mstatus.MIE=0 with pending interrupt");
    mip = 32'h80; mie = 32'h80; mstatus = 32'h0; int_allow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mie0 ready", {31'd0, ready}, 32'd1);
      check("mie0 we", {31'd0, we}, 32'd0);
      check("mie0 int_taken", {31'd0, int_taken}, 32'd0);
    end
    clear_reqs();
    mip = '0; mie = '0;

    // Back-to-back exceptions; inputs change mid-sequence without effect
    exc_valid = 1'b1; exc_cause = 32'd2; exc_pc = 32'h500; exc_tval = 32'h1;
    mtvec = 32'h40; mstatus = 32'h8;
    tick();
    exc_cause = 32'd7; exc_pc = 32'h600; exc_tval = 32'h2; mtvec = 32'h82; mstatus = 32'h0;
    expect_write("b2b1 mepc", 12'h341, 32'h500);
    expect_write("b2b1 mcause", 12'h342, 32'd2);
    expect_write("b2b1 mtval", 12'h343, 32'h1);
    expect_write("b2b1 mstatus", 12'h300, 32'h1880);
    expect_redirect("b2b1", 32'h40);
    tick();
    clear_reqs();
    expect_write("b2b2 mepc", 12'h341, 32'h600);
    expect_write("b2b2 mcause", 12'h342, 32'd7);
    expect_write("b2b2 mtval", 12'h343, 32'h2);
    expect_write("b2b2 mstatus", 12'h300, 32'h1800);
    expect_redirect("b2b2", 32'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
